seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Dynamic-lighting (time-multiplexed) scan driver for a common-anode multi-digit seven-segment display. It consumes the one-cycle clock-enable pulse produced by the dynamic-lighting divider and steps one digit per scan slot, with an optional blanking gap between digits to suppress ghosting. Each digit's hex nibble is decoded to segments, and leading-zero suppression is applied. Display data is snapshotted once per frame, so a frame never shows a mix of old and new values.

## Interface
- DIGITS, 4: number of digits scanned; legal range 2..8.
- BLANK_CE, 1: CE ticks of all-off gap after each digit; legal range 0..3.
- ZERO_SUPPRESS, 1: 1 = blank leading zeros; 0 = show every digit.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, 40 MHz (25 ns period).
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  scan-slot tick from the divider's CEOUT; one CLK wide.
- EN  in  1  display enable; 0 = all digits dark.
- DATA  in  4*DIGITS  hex nibble per digit; DATA[3:0] = digit 0 (rightmost).
- DP  in  DIGITS  decimal point per digit; bit k = digit k.
- AN  out  DIGITS  digit anodes, active-low; at most one bit low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- SEGDP  out  1  decimal-point segment, active-low.
- FRAME  out  1  one-CLK pulse on the cycle the outputs switch to digit 0.

## Operation
- State machine has three states: IDLE, SHOW and BLANK. There is a digit index IDX (0..DIGITS-1), a gap counter GAP (0..BLANK_CE), and shadow registers SH_DATA/SH_DP.
- **IDLE:** all outputs inactive. CE is ignored. When EN=1, the next CLK:
  - loads the shadow registers from DATA/DP;
  - sets IDX=0 and enters SHOW;
  - pulses FRAME.
- **SHOW:** AN bit IDX driven low; SEG/SEGDP show the decoded SH_DATA nibble and SH_DP bit for IDX. On CE:
  - if BLANK_CE>0: enter BLANK with GAP=1.
  - if BLANK_CE=0: advance IDX and stay in SHOW.
- **BLANK:** AN all high, SEG=7'h7F, SEGDP=1. On CE:
  - if GAP==BLANK_CE: advance IDX and enter SHOW;
  - otherwise GAP increments.
- **Advance:** IDX = IDX+1. When IDX == DIGITS-1 it wraps to 0. On wrap, the same CLK reloads the shadow registers from DATA/DP and FRAME pulses.
- **EN=0 in any state:** next CLK enters IDLE, clears IDX and GAP, and turns outputs off. EN=0 has priority over CE.
- **Decode** (active-high gfedcba, then inverted onto SEG): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- **Zero suppression** (ZERO_SUPPRESS=1): digit k>0 is blanked when its nibble is 0, every higher digit's nibble is 0, and DP[k]=0. A blanked digit has SEG=7'h7F and SEGDP=1 but AN[k] still low; scan timing is unchanged. Digit 0 is never suppressed.
- DATA/DP changes mid-frame have no visible effect until the next wrap.

## Timing
- Reset: AN = all ones, SEG=7'h7F, SEGDP=1, FRAME=0, state IDLE, IDX=0, GAP=0, shadow registers = 0.
- All outputs are registered. They change on the CLK edge after the CE/EN sample, i.e. 1-CLK latency. No output changes on cycles without CE, except on EN transitions.
- Slot length is one CE period. Frame period is DIGITS*(1+BLANK_CE) CE periods; with DIGITS=4 and BLANK_CE=1 that is 8 CE ticks.
- EN rising and CE on the same cycle: the start takes effect and CE is ignored. The first SHOW slot of digit 0 runs until the next CE.
- Reset asserted mid-frame: outputs go inactive asynchronously, with no glitch to an active digit. After RST_N rises, the block starts from IDLE; if EN=1 it shows digit 0 one CLK later.
- CE held high for several CLKs counts as one tick per CLK; the divider guarantees single-cycle pulses.

## Test plan
- **Reset:** RST_N=0 mid-scan, then release with EN=0 → AN=4'hF, SEG=7'h7F, SEGDP=1, FRAME=0 continuously.
- **Basic scan**, defaults, DATA=16'h1234, DP=0, EN=1, CE every 40 CLK → sequence of (AN,SEG), each blank step = (4'hF,7'h7F):
  - (4'hE,7'h19 "4"), blank,
  - (4'hD,7'h30 "3"), blank,
  - (4'hB,7'h24 "2"), blank,
  - (4'h7,7'h79 "1"), blank,
  - repeat.
  - FRAME pulses once per 8 CE ticks.
- **Zero suppression:** DATA=16'h0070, DP=4'b0000:
  - digits 3 and 2 show SEG=7'h7F; digit 1 SEG=7'h78 ("7"); digit 0 SEG=7'h40 ("0").
  - With DP=4'b0100, digit 2 shows SEG=7'h40 and SEGDP=0.
- **Snapshot:** change DATA from 16'h1234 to 16'hABCD while digit 1 is shown → digits 2 and 3 still show 2 and 1. ABCD appears only from the slot after the next FRAME pulse.
- **Enable:**
  - EN=0 during digit 2 → next CLK all outputs off.
  - EN=1 asserted on the same cycle as CE → next CLK shows digit 0 with FRAME=1, and digit 0 holds until the following CE.
- **BLANK_CE=0, DIGITS=8:** 8 consecutive SHOW slots with no off gap; AN steps 8'hFE → 8'h7F; FRAME pulses every 8 CE ticks.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// Steps one digit per CE slot with optional blank gaps; display data is latched once per frame.
module seven_seg_scan_driver #(
  parameter int DIGITS        = 4,
  parameter int BLANK_CE      = 1,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic                  EN,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  SEGDP,
  output logic                  FRAME
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [1:0]       GAP_END  = 2'(BLANK_CE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [1:0]            gap, gap_n;
  logic [4*DIGITS-1:0]   sh_data, sh_data_n;
  logic [DIGITS-1:0]     sh_dp, sh_dp_n;
  logic                  advance;
  logic                  frame_n;
  logic [DIGITS-1:0]     an_n;
  logic [6:0]            seg_n;
  logic                  segdp_n;
  logic [DIGITS-1:0]     sup_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit k>0 goes dark when it and every digit above it is zero and its own DP is off.
  function automatic logic [DIGITS-1:0] zs_mask(input logic [4*DIGITS-1:0] d,
                                                input logic [DIGITS-1:0]   p);
    logic [DIGITS-1:0] m;
    logic              upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    if (ZERO_SUPPRESS != 0) begin
      for (int k = DIGITS - 1; k > 0; k--) begin
        upper_zero = upper_zero & (d[4*k +: 4] == 4'h0);
        m[k]       = upper_zero & ~p[k];
      end
    end
    return m;
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_n     = gap;
    sh_data_n = sh_data;
    sh_dp_n   = sh_dp;
    frame_n   = 1'b0;
    advance   = 1'b0;

    if (!EN) begin
      state_n = IDLE;
      idx_n   = '0;
      gap_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = SHOW;
          idx_n     = '0;
          gap_n     = '0;
          sh_data_n = DATA;
          sh_dp_n   = DP;
          frame_n   = 1'b1;
        end
        SHOW: begin
          if (CE) begin
            if (BLANK_CE > 0) begin
              state_n = BLANK;
              gap_n   = 2'd1;
            end else begin
              advance = 1'b1;
            end
          end
        end
        BLANK: begin
          if (CE) begin
            if (gap == GAP_END) begin
              advance = 1'b1;
            end else begin
              gap_n = gap + 2'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          gap_n   = '0;
        end
      endcase

      // Wrapping back to digit 0 is the only point where new display data is taken.
      if (advance) begin
        state_n = SHOW;
        gap_n   = '0;
        if (idx == LAST_IDX) begin
          idx_n     = '0;
          sh_data_n = DATA;
          sh_dp_n   = DP;
          frame_n   = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    end
  end

  assign sup_mask = zs_mask(sh_data_n, sh_dp_n);

  always_comb begin
    an_n    = '1;
    seg_n   = 7'h7F;
    segdp_n = 1'b1;
    if (state_n == SHOW) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_n == IDX_W'(k)) begin
          an_n[k] = 1'b0;
          if (!sup_mask[k]) begin
            seg_n   = ~hex_to_seg(sh_data_n[4*k +: 4]);
            segdp_n = ~sh_dp_n[k];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      idx     <= '0;
      gap     <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
      AN      <= '1;
      SEG     <= 7'h7F;
      SEGDP   <= 1'b1;
      FRAME   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      gap     <= gap_n;
      sh_data <= sh_data_n;
      sh_dp   <= sh_dp_n;
      AN      <= an_n;
      SEG     <= seg_n;
      SEGDP   <= segdp_n;
      FRAME   <= frame_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 4-digit/1-gap instance and an 8-digit/no-gap instance
// checked every cycle against a slot-position model, plus hand-computed spot values.
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data1 = 16'h0;
  logic [3:0]  dp1 = 4'h0;
  logic [31:0] data2 = 32'h76543210;
  logic [7:0]  dp2 = 8'h00;

  logic [3:0]  an1;
  logic [6:0]  seg1;
  logic        segdp1, frame1;
  logic [7:0]  an2;
  logic [6:0]  seg2;
  logic        segdp2, frame2;

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  seven_seg_scan_driver #(.DIGITS(4), .BLANK_CE(1), .ZERO_SUPPRESS(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .EN(en), .DATA(data1), .DP(dp1),
    .AN(an1), .SEG(seg1), .SEGDP(segdp1), .FRAME(frame1)
  );

  seven_seg_scan_driver #(.DIGITS(8), .BLANK_CE(0), .ZERO_SUPPRESS(0)) dut2 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .EN(en), .DATA(data2), .DP(dp2),
    .AN(an2), .SEG(seg2), .SEGDP(segdp2), .FRAME(frame2)
  );

  always #12.5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: position within the frame counted in CE slots; slot/(B+1) is the digit, nonzero remainder is a gap.
  bit          act1 = 1'b0, act2 = 1'b0;
  int          slot1 = 0, slot2 = 0;
  logic [15:0] md1 = '0;
  logic [3:0]  mp1 = '0;
  logic [31:0] md2 = '0;
  logic [7:0]  mp2 = '0;
  bit          fr1 = 1'b0, fr2 = 1'b0;

  function automatic logic [15:0] expect_out(input int b, input bit zs, input bit act,
                                             input int slot, input logic [31:0] d,
                                             input logic [7:0] p);
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        sdp;
    logic [31:0] upper;
    int          dig;
    an  = 8'hFF;
    seg = 7'h7F;
    sdp = 1'b1;
    if (act && (slot % (b + 1)) == 0) begin
      dig     = slot / (b + 1);
      upper   = d >> (4 * dig);
      an[dig] = 1'b0;
      if (!(zs && dig > 0 && upper == 32'h0 && !p[dig])) begin
        seg = ~hex_tab[upper[3:0]];
        sdp = ~p[dig];
      end
    end
    return {an, seg, sdp};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1 <= 1'b0; slot1 <= 0; md1 <= '0; mp1 <= '0; fr1 <= 1'b0;
    end else if (!en) begin
      act1 <= 1'b0; slot1 <= 0; fr1 <= 1'b0;
    end else if (!act1) begin
      act1 <= 1'b1; slot1 <= 0; md1 <= data1; mp1 <= dp1; fr1 <= 1'b1;
    end else begin
      fr1 <= 1'b0;
      if (ce) begin
        slot1 <= (slot1 == 7) ? 0 : slot1 + 1;
        if (slot1 == 7) begin
          md1 <= data1; mp1 <= dp1; fr1 <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act2 <= 1'b0; slot2 <= 0; md2 <= '0; mp2 <= '0; fr2 <= 1'b0;
    end else if (!en) begin
      act2 <= 1'b0; slot2 <= 0; fr2 <= 1'b0;
    end else if (!act2) begin
      act2 <= 1'b1; slot2 <= 0; md2 <= data2; mp2 <= dp2; fr2 <= 1'b1;
    end else begin
      fr2 <= 1'b0;
      if (ce) begin
        slot2 <= (slot2 == 7) ? 0 : slot2 + 1;
        if (slot2 == 7) begin
          md2 <= data2; mp2 <= dp2; fr2 <= 1'b1;
        end
      end
    end
  end

  logic [15:0] exp1, exp2;
  assign exp1 = expect_out(1, 1'b1, act1, slot1, {16'h0, md1}, {4'h0, mp1});
  assign exp2 = expect_out(0, 1'b0, act2, slot2, md2, mp2);

  always @(negedge clk) begin
    if (chk_on) begin
      nvec++;
      if ({an1, seg1, segdp1, frame1} !== {exp1[11:0], fr1}) begin
        nerr++;
        $display("FAIL cycle4 t=%0t: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b",
                 $time, an1, seg1, segdp1, frame1, exp1[11:8], exp1[7:1], exp1[0], fr1);
      end
      nvec++;
      if ({an2, seg2, segdp2, frame2} !== {exp2, fr2}) begin
        nerr++;
        $display("FAIL cycle8 t=%0t: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b",
                 $time, an2, seg2, segdp2, frame2, exp2[15:8], exp2[7:1], exp2[0], fr2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      ce = 1'b1;
      tick(1);
      ce = 1'b0;
      tick(3);
    end
  endtask

  task automatic restart(input logic [15:0] d, input logic [3:0] p);
    en = 1'b0;
    tick(1);
    data1 = d;
    dp1   = p;
    en    = 1'b1;
    tick(1);
  endtask

  logic [3:0] scan_an  [8] = '{4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
  logic [6:0] scan_seg [8] = '{7'h7F, 7'h30, 7'h7F, 7'h24, 7'h7F, 7'h79, 7'h7F, 7'h19};

  initial begin
    tick(2);
    chk_on = 1'b1;
    chk("rst_an", an1, 4'hF);
    chk("rst_seg", seg1, 7'h7F);
    chk("rst_segdp", segdp1, 1'b1);
    chk("rst_frame", frame1, 1'b0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_an", an1, 4'hF);

    // Basic scan of 1234 with CE every 40 clocks
    data1 = 16'h1234;
    en    = 1'b1;
    tick(1);
    chk("start_an", an1, 4'hE);
    chk("start_seg", seg1, 7'h19);
    chk("start_frame", frame1, 1'b1);
    chk("start_an8", an2, 8'hFE);
    chk("start_seg8", seg2, 7'h40);
    tick(1);
    chk("start_frame_end", frame1, 1'b0);
    tick(38);
    for (int i = 0; i < 16; i++) begin
      ce = 1'b1;
      tick(1);
      ce = 1'b0;
      if (i < 8) begin
        chk($sformatf("scan%0d_an", i), an1, scan_an[i]);
        chk($sformatf("scan%0d_seg", i), seg1, scan_seg[i]);
        chk($sformatf("scan%0d_frame", i), frame1, (i == 7) ? 1 : 0);
      end
      if (i == 6) begin
        chk("scan8_last_an", an2, 8'h7F);
        chk("scan8_last_seg", seg2, 7'h78);
      end
      if (i == 7) begin
        chk("scan8_wrap_an", an2, 8'hFE);
        chk("scan8_wrap_frame", frame2, 1'b1);
      end
      tick(39);
    end

    // Reset in the middle of a frame, released with EN low
    step(2);
    chk("pre_rst_an", an1, 4'hD);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an1, 4'hF);
    chk("async_rst_seg", seg1, 7'h7F);
    chk("async_rst_frame", frame1, 1'b0);
    en = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_an", an1, 4'hF);
    chk("post_rst_segdp", segdp1, 1'b1);
    en = 1'b1;
    tick(1);
    chk("post_rst_start_an", an1, 4'hE);
    chk("post_rst_start_frame", frame1, 1'b1);
    tick(2);

    // Leading-zero suppression
    restart(16'h0070, 4'b0000);
    chk("zs_d0_seg", seg1, 7'h40);
    step(2);
    chk("zs_d1_an", an1, 4'hD);
    chk("zs_d1_seg", seg1, 7'h78);
    step(2);
    chk("zs_d2_an", an1, 4'hB);
    chk("zs_d2_seg", seg1, 7'h7F);
    chk("zs_d2_segdp", segdp1, 1'b1);
    step(2);
    chk("zs_d3_an", an1, 4'h7);
    chk("zs_d3_seg", seg1, 7'h7F);
    dp1 = 4'b0100;
    step(2);
    chk("zs_wrap_frame", frame1, 1'b0);
    step(4);
    chk("zsdp_d2_an", an1, 4'hB);
    chk("zsdp_d2_seg", seg1, 7'h40);
    chk("zsdp_d2_segdp", segdp1, 1'b0);
    step(2);
    chk("zsdp_d3_seg", seg1, 7'h7F);

    // Snapshot: new data mid-frame waits for the wrap
    restart(16'h1234, 4'b0000);
    step(2);
    chk("snap_d1_seg", seg1, 7'h30);
    data1 = 16'hABCD;
    step(2);
    chk("snap_d2_an", an1, 4'hB);
    chk("snap_d2_seg", seg1, 7'h24);
    step(2);
    chk("snap_d3_seg", seg1, 7'h79);
    step(1);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    chk("snap_wrap_an", an1, 4'hE);
    chk("snap_wrap_seg", seg1, 7'h21);
    chk("snap_wrap_frame", frame1, 1'b1);
    tick(3);
    step(2);
    chk("snap_new_d1_seg", seg1, 7'h46);

    // Enable drop and restart coinciding with CE
    restart(16'h1234, 4'b0000);
    step(4);
    chk("en_d2_an", an1, 4'hB);
    en = 1'b0;
    tick(1);
    chk("en_off_an", an1, 4'hF);
    chk("en_off_seg", seg1, 7'h7F);
    chk("en_off_segdp", segdp1, 1'b1);
    chk("en_off_frame", frame1, 1'b0);
    tick(2);
    en = 1'b1;
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    chk("en_ce_an", an1, 4'hE);
    chk("en_ce_seg", seg1, 7'h19);
    chk("en_ce_frame", frame1, 1'b1);
    tick(3);
    chk("en_ce_hold_an", an1, 4'hE);
    chk("en_ce_hold_frame", frame1, 1'b0);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    chk("en_ce_next_an", an1, 4'hF);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
